// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings and FSM states.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_NOTA = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_n.sv
// WIDTH-bit adder/subtractor (a + b + cin, or a + ~b + 1) with carry-out and signed overflow.
// Purely combinational; shared by ADD, SUB and SLT.
module addsub_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_overflow
);

  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;
  logic [WIDTH-1:0] w_low;
  logic [1:0]       w_top;

  assign w_b_eff = i_sub ? ~i_b : i_b;
  assign w_c0    = i_sub ? 1'b1 : i_cin;

  // Split at the MSB so the carry into it is visible for the overflow term.
  assign w_low = {1'b0, i_a[WIDTH-2:0]} + {1'b0, w_b_eff[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, w_c0};
  assign w_top = {1'b0, i_a[WIDTH-1]} + {1'b0, w_b_eff[WIDTH-1]} + {1'b0, w_low[WIDTH-1]};

  assign o_sum      = {w_top[0], w_low[WIDTH-2:0]};
  assign o_cout     = w_top[1];
  assign o_overflow = w_top[1] ^ w_low[WIDTH-1];

endmodule

// File: rtl/alu_seq.sv
// Sequential WIDTH-bit ALU with valid/ready handshakes; one op in flight, registered result.
// ALU_MUL_EN enables the iterative shift-add multiply (latency WIDTH+1); otherwise op 111 is flagged illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  input  logic             i_cin,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_illegal
);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_overflow;
  logic             r_zero;
  logic             r_illegal;

  logic [WIDTH-1:0] w_sum;
  logic             w_as_cout;
  logic             w_as_ovf;
  logic             w_sub;
  logic [WIDTH-1:0] w_res;
  logic             w_cout;
  logic             w_ovf;
  logic             w_illegal;

  // SLT reuses the subtractor: sign of (a-b) corrected by overflow.
  assign w_sub = (i_op == OP_SUB) || (i_op == OP_SLT);

  addsub_n #(.WIDTH(WIDTH)) u_addsub (
    .i_a        (i_a),
    .i_b        (i_b),
    .i_cin      (i_cin),
    .i_sub      (w_sub),
    .o_sum      (w_sum),
    .o_cout     (w_as_cout),
    .o_overflow (w_as_ovf)
  );

  always_comb begin
    w_res     = '0;
    w_cout    = 1'b0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
    case (i_op)
      OP_AND:  w_res = i_a & i_b;
      OP_OR:   w_res = i_a | i_b;
      OP_NOTA: w_res = ~i_a;
      OP_XOR:  w_res = i_a ^ i_b;
      OP_ADD, OP_SUB: begin
        w_res  = w_sum;
        w_cout = w_as_cout;
        w_ovf  = w_as_ovf;
      end
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_as_ovf};
      default: begin
`ifndef ALU_MUL_EN
        w_illegal = 1'b1;
`endif
      end
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_acc_nxt;

  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
`ifdef ALU_MUL_EN
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_in_ready <= 1'b0;
`ifdef ALU_MUL_EN
            if (i_op == OP_MUL) begin
              r_acc    <= '0;
              r_mcand  <= i_a;
              r_mplier <= i_b;
              r_cnt    <= '0;
              r_state  <= ST_MUL;
            end else
`endif
            begin
              r_result    <= w_res;
              r_cout      <= w_cout;
              r_overflow  <= w_ovf;
              r_zero      <= (w_res == '0);
              r_illegal   <= w_illegal;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
`ifdef ALU_MUL_EN
        ST_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          // Fixed WIDTH iterations regardless of operand values.
          if (r_cnt == LAST) begin
            r_result    <= w_acc_nxt;
            r_cout      <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= (w_acc_nxt == '0);
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_cout      = r_cout;
  assign o_overflow  = r_overflow;
  assign o_zero      = r_zero;
  assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Directed table-driven bench for alu_seq (WIDTH=8) plus back-pressure and reset corner sequences.
module tb_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       cout;
  logic       overflow;
  logic       zero;
  logic       illegal;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq #(.WIDTH(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a),
    .i_b         (b),
    .i_op        (op),
    .i_cin       (cin),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_result    (result),
    .o_cout      (cout),
    .o_overflow  (overflow),
    .o_zero      (zero),
    .o_illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
    logic       ill;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(input logic [2:0] vop, input logic [7:0] va, input logic [7:0] vb,
                               input logic vcin, input logic [7:0] vres, input logic vc,
                               input logic vv, input logic vz, input logic vill, input int vlat);
    vec_t t;
    t.op = vop; t.a = va; t.b = vb; t.cin = vcin;
    t.res = vres; t.c = vc; t.v = vv; t.z = vz; t.ill = vill; t.lat = vlat;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns cycles from accept to out_valid.
  task automatic run_op(input logic [2:0] vop, input logic [7:0] va, input logic [7:0] vb,
                        input logic vcin, output int lat);
    in_valid = 1'b1; op = vop; a = va; b = vb; cin = vcin;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'hxx; b = 8'hxx; op = 3'bxxx; cin = 1'bx;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
    chk({nm, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // op, a, b, cin, result, cout, ovf, zero, illegal, latency
    addv(3'b010, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    addv(3'b010, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    addv(3'b010, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    addv(3'b100, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    addv(3'b100, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    addv(3'b100, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    addv(3'b100, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    addv(3'b000, 8'hC3, 8'h5A, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    addv(3'b001, 8'hC3, 8'h5A, 1'b0, 8'hDB, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    addv(3'b101, 8'hC3, 8'h5A, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    addv(3'b011, 8'hC3, 8'h5A, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    addv(3'b101, 8'hA5, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    addv(3'b110, 8'hFE, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    addv(3'b110, 8'h01, 8'hFE, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    addv(3'b110, 8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1);
`ifdef ALU_MUL_EN
    addv(3'b111, 8'h0D, 8'h0B, 1'b0, 8'h8F, 1'b0, 1'b0, 1'b0, 1'b0, 9);
    addv(3'b111, 8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9);
    addv(3'b111, 8'h37, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9);
    addv(3'b111, 8'hFF, 8'hFF, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 9);
`else
    addv(3'b111, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1);
`endif

    // Reset with random inputs toggling
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00; op = 3'b000; cin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
    end
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_flags", {28'd0, cout, overflow, zero, illegal}, 32'd0);
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_result", i), {24'd0, result}, {24'd0, vecs[i].res});
      chk($sformatf("v%0d_cout", i), {31'd0, cout}, {31'd0, vecs[i].c});
      chk($sformatf("v%0d_overflow", i), {31'd0, overflow}, {31'd0, vecs[i].v});
      chk($sformatf("v%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].z});
      chk($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
      chk($sformatf("v%0d_in_ready_busy", i), {31'd0, in_ready}, 32'd0);
      release_out($sformatf("v%0d", i));
    end

    // Back-pressure: result held, new requests ignored while DONE
    run_op(3'b010, 8'h0F, 8'h01, 1'b0, lat);
    chk("bp_latency", lat, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 3'b001; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("bp%0d_result", i), {24'd0, result}, 32'h10);
      chk($sformatf("bp%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    release_out("bp");
    run_op(3'b101, 8'hF0, 8'h0F, 1'b0, lat);
    chk("bp_next_result", {24'd0, result}, 32'hFF);
    release_out("bp_next");

    // Reset while DONE drops out_valid asynchronously
    run_op(3'b001, 8'h81, 8'h18, 1'b0, lat);
    chk("rdone_valid_before", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rdone_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rdone_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rdone_result", {24'd0, result}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef ALU_MUL_EN
    // Reset four cycles into a multiply; no stale result may appear
    in_valid = 1'b1; op = 3'b111; a = 8'h0D; b = 8'h0B; cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rmul_busy_in_ready", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rmul_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rmul_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("rmul_no_stale_valid", {31'd0, out_valid}, 32'd0);
    chk("rmul_no_stale_result", {24'd0, result}, 32'd0);
    chk("rmul_idle_in_ready", {31'd0, in_ready}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
